// File: rtl/nukv_privacy_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nukv_privacy_arbiter
// Purpose  : Round-robin arbiter between two value requesters feeding a
//            privacy pipeline; results are routed back by an in-order tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module nukv_privacy_arbiter #(
    parameter int MEMORY_WIDTH = 512,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [MEMORY_WIDTH-1:0] req0_data,
    input  logic                    req0_last,
    input  logic                    req0_priv,
    input  logic                    req0_valid,
    output logic                    req0_ready,

    input  logic [MEMORY_WIDTH-1:0] req1_data,
    input  logic                    req1_last,
    input  logic                    req1_priv,
    input  logic                    req1_valid,
    output logic                    req1_ready,

    output logic                    pipe_pred_data,
    output logic                    pipe_pred_valid,
    input  logic                    pipe_pred_ready,

    output logic [MEMORY_WIDTH-1:0] pipe_value_data,
    output logic                    pipe_value_valid,
    input  logic                    pipe_value_ready,

    input  logic [MEMORY_WIDTH-1:0] pipe_out_data,
    input  logic                    pipe_out_valid,
    input  logic                    pipe_out_last,
    output logic                    pipe_out_ready,

    output logic [MEMORY_WIDTH-1:0] resp0_data,
    output logic                    resp0_valid,
    output logic                    resp0_last,
    input  logic                    resp0_ready,

    output logic [MEMORY_WIDTH-1:0] resp1_data,
    output logic                    resp1_valid,
    output logic                    resp1_last,
    input  logic                    resp1_ready,

    output logic [31:0]             grant_cnt0,
    output logic [31:0]             grant_cnt1
);

    localparam logic [4:0] c_max_inflight = 5'(MAX_INFLIGHT);
    localparam logic [4:0] c_tag_depth    = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRED = 2'd1,
        ST_FWD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_rr;
    logic        r_id;
    logic        r_priv;
    logic [4:0]  r_inflight;
    logic [15:0] r_tag;
    logic [3:0]  r_wr_ptr;
    logic [3:0]  r_rd_ptr;
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;

    logic w_grant;
    logic w_grant_id;
    logic w_beat_last;
    logic w_fwd_done;
    logic w_head;
    logic w_nonempty;
    logic w_pop;

    // Tag FIFO occupancy always equals the inflight count, so one counter serves both.
    assign w_grant    = (r_state == ST_IDLE) && (req0_valid || req1_valid) &&
                        (r_inflight < c_max_inflight) && (r_inflight != c_tag_depth);
    assign w_grant_id = (req0_valid && req1_valid) ? r_rr : req1_valid;

    assign w_beat_last = r_id ? (req1_valid && req1_last) : (req0_valid && req0_last);
    assign w_fwd_done  = (r_state == ST_FWD) && pipe_value_ready && w_beat_last;

    always_comb begin
        w_state_next     = r_state;
        pipe_pred_valid  = 1'b0;
        pipe_value_valid = 1'b0;
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) w_state_next = ST_PRED;
            end
            ST_PRED: begin
                pipe_pred_valid = 1'b1;
                if (pipe_pred_ready) w_state_next = ST_FWD;
            end
            ST_FWD: begin
                pipe_value_valid = r_id ? req1_valid : req0_valid;
                req0_ready       = !r_id && pipe_value_ready;
                req1_ready       = r_id && pipe_value_ready;
                if (w_fwd_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign pipe_pred_data  = r_priv;
    assign pipe_value_data = r_id ? req1_data : req0_data;

    // Return path is purely combinational from the FIFO head.
    assign w_head         = r_tag[r_rd_ptr];
    assign w_nonempty     = (r_inflight != 5'd0);
    assign pipe_out_ready = w_nonempty && (w_head ? resp1_ready : resp0_ready);
    assign w_pop          = pipe_out_valid && pipe_out_ready && pipe_out_last;

    assign resp0_data  = pipe_out_data;
    assign resp0_last  = pipe_out_last;
    assign resp0_valid = w_nonempty && !w_head && pipe_out_valid;
    assign resp1_data  = pipe_out_data;
    assign resp1_last  = pipe_out_last;
    assign resp1_valid = w_nonempty && w_head && pipe_out_valid;

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr         <= 1'b0;
            r_id         <= 1'b0;
            r_priv       <= 1'b0;
            r_inflight   <= 5'd0;
            r_tag        <= 16'd0;
            r_wr_ptr     <= 4'd0;
            r_rd_ptr     <= 4'd0;
            r_grant_cnt0 <= 32'd0;
            r_grant_cnt1 <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_id            <= w_grant_id;
                r_priv          <= w_grant_id ? req1_priv : req0_priv;
                r_tag[r_wr_ptr] <= w_grant_id;
                r_wr_ptr        <= r_wr_ptr + 4'd1;
                if (w_grant_id) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
                else            r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 4'd1;
            if (w_grant && !w_pop)      r_inflight <= r_inflight + 5'd1;
            else if (!w_grant && w_pop) r_inflight <= r_inflight - 5'd1;
            if (w_fwd_done) r_rr <= ~r_id;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nukv_privacy_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nukv_privacy_arbiter
// Purpose  : Directed bench with a transaction-level reference model and a
//            loopback pipeline; compares DUT outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nukv_privacy_arbiter;

    localparam int W    = 64;
    localparam int MAXI = 4;

    typedef struct {
        int nb;
        bit pv;
        int tag;
    } val_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         req0_last = 0, req0_priv = 0, req0_valid = 0, req0_ready;
    logic         req1_last = 0, req1_priv = 0, req1_valid = 0, req1_ready;
    logic         pipe_pred_data, pipe_pred_valid, pipe_pred_ready = 1;
    logic [W-1:0] pipe_value_data;
    logic         pipe_value_valid, pipe_value_ready = 1;
    logic [W-1:0] pipe_out_data = '0;
    logic         pipe_out_valid = 0, pipe_out_last = 0, pipe_out_ready;
    logic [W-1:0] resp0_data, resp1_data;
    logic         resp0_valid, resp0_last, resp0_ready = 1;
    logic         resp1_valid, resp1_last, resp1_ready = 1;
    logic [31:0]  grant_cnt0, grant_cnt1;

    nukv_privacy_arbiter #(.MEMORY_WIDTH(W), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst(rst),
        .req0_data(req0_data), .req0_last(req0_last), .req0_priv(req0_priv),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_last(req1_last), .req1_priv(req1_priv),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .pipe_pred_data(pipe_pred_data), .pipe_pred_valid(pipe_pred_valid),
        .pipe_pred_ready(pipe_pred_ready),
        .pipe_value_data(pipe_value_data), .pipe_value_valid(pipe_value_valid),
        .pipe_value_ready(pipe_value_ready),
        .pipe_out_data(pipe_out_data), .pipe_out_valid(pipe_out_valid),
        .pipe_out_last(pipe_out_last), .pipe_out_ready(pipe_out_ready),
        .resp0_data(resp0_data), .resp0_valid(resp0_valid), .resp0_last(resp0_last),
        .resp0_ready(resp0_ready),
        .resp1_data(resp1_data), .resp1_valid(resp1_valid), .resp1_last(resp1_last),
        .resp1_ready(resp1_ready),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: requester phase (0 idle, 1 pred, 2 fwd) plus tag queue.
    int          m_phase;
    bit          m_id, m_priv, m_rr;
    bit          m_tags[$];
    logic [31:0] m_cnt0, m_cnt1;
    bit          e_vv, e_r0, e_r1, e_or, e_rv0, e_rv1, m_ne, m_head, m_cangrant, m_gid;

    task automatic model_reset();
        m_phase = 0; m_id = 0; m_priv = 0; m_rr = 0;
        m_tags.delete();
        m_cnt0 = 0; m_cnt1 = 0;
    endtask

    initial model_reset();

    // Handshakes observed at the falling edge; inputs stay put until after the next rising edge.
    bit           h_pred, h_pred_d, h_v, h_r0, h_r1, h_out, h_rs0, h_rs1;
    logic [W-1:0] cap_v_data, cap_rs0_d, cap_rs1_d;
    bit           cap_rs0_l, cap_rs1_l;

    always @(negedge clk) begin
        if (rst) model_reset();
        chk("pred_valid", 64'(pipe_pred_valid), 64'(m_phase == 1));
        if (m_phase == 1) chk("pred_data", 64'(pipe_pred_data), 64'(m_priv));
        e_vv = (m_phase == 2) && (m_id ? req1_valid : req0_valid);
        e_r0 = (m_phase == 2) && !m_id && pipe_value_ready;
        e_r1 = (m_phase == 2) && m_id && pipe_value_ready;
        chk("value_valid", 64'(pipe_value_valid), 64'(e_vv));
        if (e_vv) chk("value_data", pipe_value_data, m_id ? req1_data : req0_data);
        chk("req0_ready", 64'(req0_ready), 64'(e_r0));
        chk("req1_ready", 64'(req1_ready), 64'(e_r1));
        m_ne   = m_tags.size() != 0;
        m_head = m_ne ? m_tags[0] : 1'b0;
        e_or   = m_ne && (m_head ? resp1_ready : resp0_ready);
        e_rv0  = m_ne && !m_head && pipe_out_valid;
        e_rv1  = m_ne && m_head && pipe_out_valid;
        chk("out_ready", 64'(pipe_out_ready), 64'(e_or));
        chk("resp0_valid", 64'(resp0_valid), 64'(e_rv0));
        chk("resp1_valid", 64'(resp1_valid), 64'(e_rv1));
        if (e_rv0) chk("resp0_data", resp0_data, pipe_out_data);
        if (e_rv1) chk("resp1_last", 64'(resp1_last), 64'(pipe_out_last));
        chk("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt0));
        chk("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt1));

        h_pred   = pipe_pred_valid && pipe_pred_ready;
        h_pred_d = pipe_pred_data;
        h_v      = pipe_value_valid && pipe_value_ready;
        h_r0     = req0_valid && req0_ready;
        h_r1     = req1_valid && req1_ready;
        h_out    = pipe_out_valid && pipe_out_ready;
        h_rs0    = resp0_valid && resp0_ready;
        h_rs1    = resp1_valid && resp1_ready;
        cap_v_data = pipe_value_data;
        cap_rs0_d = resp0_data; cap_rs0_l = resp0_last;
        cap_rs1_d = resp1_data; cap_rs1_l = resp1_last;

        if (!rst) begin
            m_cangrant = (req0_valid || req1_valid) && (m_tags.size() < MAXI);
            if (m_ne && pipe_out_valid && e_or && pipe_out_last) m_tags.delete(0);
            case (m_phase)
                0: if (m_cangrant) begin
                    m_gid  = (req0_valid && req1_valid) ? m_rr : req1_valid;
                    m_id   = m_gid;
                    m_priv = m_gid ? req1_priv : req0_priv;
                    m_tags.push_back(m_gid);
                    if (m_gid) m_cnt1 = m_cnt1 + 1; else m_cnt0 = m_cnt0 + 1;
                    m_phase = 1;
                end
                1: if (pipe_pred_ready) m_phase = 2;
                default: if (e_vv && pipe_value_ready && (m_id ? req1_last : req0_last)) begin
                    m_rr = !m_id;
                    m_phase = 0;
                end
            endcase
        end
    end

    // Stimulus sources, loopback pipeline and per-port scoreboards.
    val_t         s0[$], s1[$];
    int           b0 = 0, b1 = 0, ntag = 0;
    bit           out_en = 1;
    logic [W-1:0] loop_d[$], e0_d[$], e1_d[$];
    bit           loop_l[$], e0_l[$], e1_l[$];
    int           n_pred, n_pred1, n_vbeat, n_resp0, n_resp1, n_last0, n_last1;
    int           vlog[$];

    task automatic push(input int n, input int nb, input bit pv);
        val_t v;
        v.nb = nb; v.pv = pv; v.tag = 1000 * n + ntag;
        ntag++;
        if (n == 1) s1.push_back(v); else s0.push_back(v);
    endtask

    task automatic drive();
        req0_valid = !rst && s0.size() != 0;
        req1_valid = !rst && s1.size() != 0;
        if (s0.size() != 0) begin
            req0_data = {32'(s0[0].tag), 32'(b0)};
            req0_last = (b0 == s0[0].nb - 1);
            req0_priv = s0[0].pv;
        end else begin
            req0_data = '0; req0_last = 0; req0_priv = 0;
        end
        if (s1.size() != 0) begin
            req1_data = {32'(s1[0].tag), 32'(b1)};
            req1_last = (b1 == s1[0].nb - 1);
            req1_priv = s1[0].pv;
        end else begin
            req1_data = '0; req1_last = 0; req1_priv = 0;
        end
        pipe_out_valid = out_en && loop_d.size() != 0;
        pipe_out_data  = (loop_d.size() != 0) ? loop_d[0] : '0;
        pipe_out_last  = (loop_l.size() != 0) ? loop_l[0] : 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            s0.delete(); s1.delete(); loop_d.delete(); loop_l.delete();
            e0_d.delete(); e0_l.delete(); e1_d.delete(); e1_l.delete();
            b0 = 0; b1 = 0;
        end else begin
            if (h_pred) begin n_pred++; if (h_pred_d) n_pred1++; end
            if (h_v) begin
                n_vbeat++;
                loop_d.push_back(cap_v_data);
                loop_l.push_back(h_r1 ? req1_last : req0_last);
            end
            if (h_r0) begin
                e0_d.push_back(req0_data); e0_l.push_back(req0_last);
                if (req0_last) begin vlog.push_back(0); s0.delete(0); b0 = 0; end
                else b0++;
            end
            if (h_r1) begin
                e1_d.push_back(req1_data); e1_l.push_back(req1_last);
                if (req1_last) begin vlog.push_back(1); s1.delete(0); b1 = 0; end
                else b1++;
            end
            if (h_out && loop_d.size() != 0) begin loop_d.delete(0); loop_l.delete(0); end
            if (h_rs0) begin
                n_resp0++; if (cap_rs0_l) n_last0++;
                chk("resp0_pending", 64'(e0_d.size() != 0), 64'd1);
                if (e0_d.size() != 0) begin
                    chk("resp0_sb_data", cap_rs0_d, e0_d[0]);
                    chk("resp0_sb_last", 64'(cap_rs0_l), 64'(e0_l[0]));
                    e0_d.delete(0); e0_l.delete(0);
                end
            end
            if (h_rs1) begin
                n_resp1++; if (cap_rs1_l) n_last1++;
                chk("resp1_pending", 64'(e1_d.size() != 0), 64'd1);
                if (e1_d.size() != 0) begin
                    chk("resp1_sb_data", cap_rs1_d, e1_d[0]);
                    chk("resp1_sb_last", 64'(cap_rs1_l), 64'(e1_l[0]));
                    e1_d.delete(0); e1_l.delete(0);
                end
            end
        end
        drive();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_stats();
        n_pred = 0; n_pred1 = 0; n_vbeat = 0; n_resp0 = 0; n_resp1 = 0;
        n_last0 = 0; n_last1 = 0; vlog.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        ticks(2);
        rst = 1'b0;
        out_en = 1; pipe_pred_ready = 1; pipe_value_ready = 1;
        resp0_ready = 1; resp1_ready = 1;
        clr_stats();
        drive();
    endtask

    task automatic drain(input string nm, input int max);
        int k = 0;
        while ((s0.size() != 0 || s1.size() != 0 || loop_d.size() != 0 ||
                e0_d.size() != 0 || e1_d.size() != 0) && k < max) begin
            tick();
            k++;
        end
        chk(nm, 64'(k < max), 64'd1);
        ticks(3);
    endtask

    int c_order[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        clr_stats();
        drive();
        ticks(2);
        chk("reset_pred_valid", 64'(pipe_pred_valid), 64'd0);
        chk("reset_out_ready", 64'(pipe_out_ready), 64'd0);
        chk("reset_cnt0", 64'(grant_cnt0), 64'd0);
        rst = 1'b0;
        drive();

        // Single three-beat private value, with the pred held off for a few cycles.
        pipe_pred_ready = 0;
        push(0, 3, 1'b1); drive();
        ticks(4);
        pipe_pred_ready = 1;
        drain("t1_timeout", 60);
        chk("t1_cnt0", 64'(grant_cnt0), 64'd1);
        chk("t1_cnt1", 64'(grant_cnt1), 64'd0);
        chk("t1_preds", 64'(n_pred), 64'd1);
        chk("t1_pred_ones", 64'(n_pred1), 64'd1);
        chk("t1_resp0_beats", 64'(n_resp0), 64'd3);
        chk("t1_resp0_lasts", 64'(n_last0), 64'd1);
        chk("t1_out_idle", 64'(pipe_out_ready), 64'd0);

        // Contention with one-beat values from both requesters.
        do_reset();
        for (int i = 0; i < 4; i++) begin push(0, 1, 1'b0); push(1, 1, 1'b1); end
        drive();
        drain("t2_timeout", 120);
        chk("t2_values", 64'(vlog.size()), 64'd8);
        for (int i = 0; i < 8 && i < vlog.size(); i++)
            chk($sformatf("t2_order%0d", i), 64'(vlog[i]), 64'(c_order[i]));
        chk("t2_resp0", 64'(n_resp0), 64'd4);
        chk("t2_resp1", 64'(n_resp1), 64'd4);

        // Credit limit: results held back, then a single return frees one slot.
        do_reset();
        out_en = 0;
        for (int i = 0; i < 6; i++) push(0, 1, 1'b0);
        drive();
        ticks(30);
        chk("t3_preds_at_limit", 64'(n_pred), 64'd4);
        chk("t3_cnt0_at_limit", 64'(grant_cnt0), 64'd4);
        out_en = 1; drive();
        tick();
        out_en = 0; drive();
        ticks(3);
        chk("t3_fifth_grant", 64'(grant_cnt0), 64'd5);
        chk("t3_returned", 64'(n_resp0), 64'd1);
        out_en = 1; drive();
        drain("t3_timeout", 120);
        chk("t3_cnt0_final", 64'(grant_cnt0), 64'd6);

        // Response backpressure on requester 1 with its tag at the FIFO head.
        do_reset();
        resp1_ready = 0;
        push(1, 2, 1'b0); drive();
        ticks(8);
        push(0, 1, 1'b1); drive();
        ticks(15);
        chk("t4_out_ready_held", 64'(pipe_out_ready), 64'd0);
        chk("t4_resp1_none", 64'(n_resp1), 64'd0);
        chk("t4_resp0_none", 64'(n_resp0), 64'd0);
        resp1_ready = 1; drive();
        drain("t4_timeout", 60);
        chk("t4_resp1_beats", 64'(n_resp1), 64'd2);
        chk("t4_resp0_beats", 64'(n_resp0), 64'd1);

        // Grant and final-beat pop in the same cycle with two values outstanding.
        do_reset();
        out_en = 0;
        push(0, 1, 1'b0); push(0, 1, 1'b0); drive();
        ticks(12);
        chk("t5_two_out", 64'(grant_cnt0), 64'd2);
        push(1, 1, 1'b1); out_en = 1; drive();
        tick();
        out_en = 0;
        for (int i = 0; i < 3; i++) push(0, 1, 1'b0);
        drive();
        ticks(20);
        chk("t5_cnt1", 64'(grant_cnt1), 64'd1);
        chk("t5_cnt0_credit", 64'(grant_cnt0), 64'd4);
        out_en = 1; drive();
        drain("t5_timeout", 120);

        // Reset in the middle of a four-beat value.
        do_reset();
        push(0, 4, 1'b1); drive();
        begin
            int k = 0;
            while (n_vbeat < 1 && k < 20) begin tick(); k++; end
            chk("t6_reach_beat2", 64'(n_vbeat >= 1), 64'd1);
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_value_valid", 64'(pipe_value_valid), 64'd0);
        chk("t6_rst_req0_ready", 64'(req0_ready), 64'd0);
        chk("t6_rst_pred_valid", 64'(pipe_pred_valid), 64'd0);
        chk("t6_rst_cnt0", 64'(grant_cnt0), 64'd0);
        ticks(2);
        rst = 1'b0;
        clr_stats();
        pipe_pred_ready = 0;
        push(0, 2, 1'b0); drive();
        ticks(3);
        chk("t6_no_beat_before_pred", 64'(n_vbeat), 64'd0);
        pipe_pred_ready = 1; drive();
        drain("t6_timeout", 60);
        chk("t6_preds", 64'(n_pred), 64'd1);
        chk("t6_pred_ones", 64'(n_pred1), 64'd0);
        chk("t6_cnt0", 64'(grant_cnt0), 64'd1);
        chk("t6_resp0_beats", 64'(n_resp0), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
